// File: rtl/data_memory_io_pkg.sv
// Shared address map and decode types for the data memory / memory-mapped I/O block.
package data_memory_io_pkg;

    localparam logic [31:0] DATA_BASE_DEF = 32'h1001_0000;
    localparam logic [31:0] IO_BASE_DEF   = 32'hFFFF_0000;

    localparam logic [31:0] OFS_PORTOUT = 32'h0000_0000;
    localparam logic [31:0] OFS_PORTIN  = 32'h0000_0004;
    localparam logic [31:0] OFS_STATUS  = 32'h0000_0008;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RAM,
        REG_PORTOUT,
        REG_PORTIN,
        REG_STATUS
    } region_e;

endpackage

// File: rtl/data_memory_io_if.sv
// Load/store bus between the single-cycle datapath (master) and the data memory (slave).
interface data_memory_io_if;

    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        AddrError;

    modport master (
        output MemWrite, MemRead, Address, WriteData,
        input  ReadData, AddrError
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData,
        output ReadData, AddrError
    );

endinterface

// File: rtl/data_memory_io_port_in_sync.sv
// Two-flop synchronizer for the external input pins plus the optional sticky change flag
// (present only when PORTIN_CHANGE_FLAG_EN is defined).
module port_in_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] port_in_i,
    input  logic       status_clr_i,
    output logic [7:0] port_sync_o,
    output logic       change_flag_o
);

    logic [7:0] meta_q;
    logic [7:0] sync_q;

    // NOTE: state flops use non-blocking assignment so meta_q -> sync_q forms two real stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= port_in_i;
            sync_q <= meta_q;
        end
    end

    assign port_sync_o = sync_q;

`ifdef PORTIN_CHANGE_FLAG_EN
    logic [7:0] prev_q;
    logic       flag_q;
    logic       flag_d;

    // Set is applied after clear so a change on the clearing edge is never lost.
    always_comb begin
        flag_d = flag_q;
        if (status_clr_i)     flag_d = 1'b0;
        if (sync_q != prev_q) flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            flag_q <= 1'b0;
        end else begin
            prev_q <= sync_q;
            flag_q <= flag_d;
        end
    end

    assign change_flag_o = flag_q;
`else
    logic unused_clr;
    assign unused_clr    = status_clr_i;
    assign change_flag_o = 1'b0;
`endif

endmodule

// File: rtl/data_memory_io.sv
// Zero-latency data RAM plus memory-mapped PortOut / PortIn / STATUS registers for a
// single-cycle CPU. Optional PortIn change flag: define PORTIN_CHANGE_FLAG_EN.
module data_memory_io
    import data_memory_io_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 64,
    parameter logic [31:0] DATA_BASE    = DATA_BASE_DEF,
    parameter logic [31:0] IO_BASE      = IO_BASE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    data_memory_io_if.slave        bus,
    input  logic [7:0]             PortIn,
    output logic [31:0]            PortOut
);

    localparam int unsigned AW        = $clog2(MEMORY_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEMORY_DEPTH);

    region_e     region;
    logic [31:0] ram_ofs;
    logic [AW-1:0] ram_idx;
    logic        addr_err;
    logic        wr_ok;
    logic        ram_we;
    logic        status_clr;
    logic [7:0]  port_sync;
    logic        change_flag;
    logic [31:0] port_out_q;
    logic [31:0] port_out_d;
    logic [31:0] ram_q [MEMORY_DEPTH];

    assign ram_ofs = bus.Address - DATA_BASE;
    assign ram_idx = ram_ofs[AW+1:2];

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        region = REG_NONE;
        if (bus.Address >= DATA_BASE && ram_ofs < RAM_BYTES) region = REG_RAM;
        else if (bus.Address == IO_BASE + OFS_PORTOUT)        region = REG_PORTOUT;
        else if (bus.Address == IO_BASE + OFS_PORTIN)         region = REG_PORTIN;
        else if (bus.Address == IO_BASE + OFS_STATUS)         region = REG_STATUS;
    end

    assign addr_err = (bus.MemRead | bus.MemWrite)
                    & ((region == REG_NONE) | (bus.Address[1:0] != 2'b00));

    // Writes are qualified by reset so an edge during reset never commits a store.
    assign wr_ok      = reset & bus.MemWrite & ~addr_err;
    assign ram_we     = wr_ok & (region == REG_RAM);
    assign status_clr = wr_ok & (region == REG_STATUS) & bus.WriteData[0];

    // NOTE: RAM has no reset; contents survive reset and start undefined after power-up.
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_idx] <= bus.WriteData;
    end

    always_comb begin
        port_out_d = port_out_q;
        if (wr_ok && region == REG_PORTOUT) port_out_d = bus.WriteData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) port_out_q <= '0;
        else        port_out_q <= port_out_d;
    end

    assign PortOut = port_out_q;

    port_in_sync u_port_in_sync (
        .clk          (clk),
        .rst_n        (reset),
        .port_in_i    (PortIn),
        .status_clr_i (status_clr),
        .port_sync_o  (port_sync),
        .change_flag_o(change_flag)
    );

    // Read path shows pre-edge contents, which also gives writes priority on read+write.
    always_comb begin
        bus.ReadData = '0;
        if (reset && bus.MemRead && !addr_err) begin
            unique case (region)
                REG_RAM:     bus.ReadData = ram_q[ram_idx];
                REG_PORTOUT: bus.ReadData = port_out_q;
                REG_PORTIN:  bus.ReadData = {24'h0, port_sync};
                REG_STATUS:  bus.ReadData = {31'h0, change_flag};
                default:     bus.ReadData = '0;
            endcase
        end
    end

    assign bus.AddrError = addr_err;

endmodule

// File: tb/tb_data_memory_io.sv
// Directed self-checking bench for data_memory_io: RAM, boundaries, alignment, I/O ports,
// STATUS flag (expectation follows PORTIN_CHANGE_FLAG_EN) and asynchronous reset.
module tb_data_memory_io;

`ifdef PORTIN_CHANGE_FLAG_EN
    localparam logic [31:0] FLAG_EN = 32'd1;
`else
    localparam logic [31:0] FLAG_EN = 32'd0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    int          n_vec;
    int          n_bad;

    data_memory_io_if bus ();

    data_memory_io dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .PortIn (PortIn),
        .PortOut(PortOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.Address   = 32'h0;
        bus.WriteData = 32'h0;
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.MemWrite  = 1'b1;
        bus.MemRead   = 1'b0;
        bus.Address   = addr;
        bus.WriteData = data;
        #1;
    endtask

    task automatic rd(input logic [31:0] addr);
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b1;
        bus.Address   = addr;
        bus.WriteData = 32'h0;
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        PortIn = 8'h00;
        idle();

        // Reset state
        rd(32'hFFFF_0000);
        check("rst_portout", PortOut, 32'h0);
        check("rst_readdata", bus.ReadData, 32'h0);
        step();
        step();
        reset = 1'b1;
        idle();

        // Store then load
        wr(32'h1001_0000, 32'h1111_1111);
        step();
        wr(32'h1001_0004, 32'hDEAD_BEEF);
        check("st_aerr", bus.AddrError, 32'h0);
        step();
        rd(32'h1001_0004);
        check("ld_word1", bus.ReadData, 32'hDEAD_BEEF);
        check("ld_aerr", bus.AddrError, 32'h0);

        // RAM upper boundary
        wr(32'h1001_00FC, 32'hCAFE_F00D);
        check("last_aerr", bus.AddrError, 32'h0);
        step();
        rd(32'h1001_00FC);
        check("last_rd", bus.ReadData, 32'hCAFE_F00D);
        wr(32'h1001_0100, 32'h1234_5678);
        check("past_end_wr_aerr", bus.AddrError, 32'h1);
        step();
        rd(32'h1001_0100);
        check("past_end_rd_aerr", bus.AddrError, 32'h1);
        check("past_end_rd_data", bus.ReadData, 32'h0);
        rd(32'h1001_0000);
        check("past_end_word0", bus.ReadData, 32'h1111_1111);
        rd(32'h1001_00FC);
        check("past_end_last", bus.ReadData, 32'hCAFE_F00D);

        // Misaligned accesses
        wr(32'h1001_0002, 32'hBAD0_BAD0);
        check("mis_wr_aerr", bus.AddrError, 32'h1);
        step();
        rd(32'h1001_0000);
        check("mis_word0", bus.ReadData, 32'h1111_1111);
        rd(32'h1001_0004);
        check("mis_word1", bus.ReadData, 32'hDEAD_BEEF);
        rd(32'h1001_0006);
        check("mis_rd_aerr", bus.AddrError, 32'h1);
        check("mis_rd_data", bus.ReadData, 32'h0);

        // Write priority with simultaneous read; no same-cycle bypass
        wr(32'h1001_0004, 32'h0BAD_F00D);
        bus.MemRead = 1'b1;
        #1;
        check("rw_pre_edge", bus.ReadData, 32'hDEAD_BEEF);
        step();
        rd(32'h1001_0004);
        check("rw_post_edge", bus.ReadData, 32'h0BAD_F00D);

        // No read strobe / unmapped addresses
        idle();
        bus.Address = 32'h1001_0004;
        #1;
        check("noread_data", bus.ReadData, 32'h0);
        check("noread_aerr", bus.AddrError, 32'h0);
        rd(32'h0000_1000);
        check("unmapped_aerr", bus.AddrError, 32'h1);
        rd(32'hFFFF_000C);
        check("io_hole_aerr", bus.AddrError, 32'h1);
        check("io_hole_data", bus.ReadData, 32'h0);

        // Output port
        wr(32'hFFFF_0000, 32'h0000_00A5);
        check("pout_pre_edge", PortOut, 32'h0);
        step();
        check("pout_post_edge", PortOut, 32'hA5);
        rd(32'hFFFF_0000);
        check("pout_rd", bus.ReadData, 32'hA5);
        wr(32'hFFFF_0004, 32'hFFFF_FFFF);
        check("pin_wr_aerr", bus.AddrError, 32'h0);
        step();
        check("pin_wr_pout", PortOut, 32'hA5);

        // Input port: two-edge synchronizer latency
        PortIn = 8'h3C;
        rd(32'hFFFF_0004);
        check("pin_edge0", bus.ReadData, 32'h0);
        step();
        check("pin_edge1", bus.ReadData, 32'h0);
        step();
        check("pin_edge2", bus.ReadData, 32'h3C);

        // STATUS change flag
        rd(32'hFFFF_0008);
        check("status_aerr", bus.AddrError, 32'h0);
        step();
        check("status_set", bus.ReadData, FLAG_EN);
        wr(32'hFFFF_0008, 32'h1);
        check("status_clr_aerr", bus.AddrError, 32'h0);
        step();
        rd(32'hFFFF_0008);
        check("status_cleared", bus.ReadData, 32'h0);
        PortIn = 8'h5A;
        step();
        step();
        wr(32'hFFFF_0008, 32'h1);
        step();
        rd(32'hFFFF_0008);
        check("status_set_wins", bus.ReadData, FLAG_EN);
        wr(32'hFFFF_0008, 32'h1);
        step();
        rd(32'hFFFF_0008);
        check("status_cleared2", bus.ReadData, 32'h0);

        // Asynchronous reset mid-cycle, write during reset discarded
        check("pout_before_rst", PortOut, 32'hA5);
        wr(32'h1001_0000, 32'h9999_9999);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_pout", PortOut, 32'h0);
        bus.MemRead = 1'b1;
        #1;
        check("rst_hold_rdata", bus.ReadData, 32'h0);
        step();
        #2;
        reset = 1'b1;
        rd(32'h1001_0000);
        check("rst_discard_wr", bus.ReadData, 32'h1111_1111);
        rd(32'hFFFF_0004);
        check("rst_sync_clear", bus.ReadData, 32'h0);
        rd(32'hFFFF_0008);
        check("rst_status_clear", bus.ReadData, 32'h0);
        check("rst_pout_stays", PortOut, 32'h0);
        step();
        step();
        rd(32'hFFFF_0004);
        check("pin_after_rst", bus.ReadData, 32'h5A);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
